// File: rtl/mux_nx1_pipe.sv
// Pipelined NUM_IN:1 multiplexer built as a registered binary tree of 2:1 muxes with valid/ready flow control.
// Define MUX_NX1_SCAN_EN to add a scan_en input that takes the select from an internal auto-incrementing counter.
module mux_nx1_pipe #(
    parameter  int NUM_IN = 32,
    parameter  int WIDTH  = 1,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef MUX_NX1_SCAN_EN
    input  logic                    scan_en,
`endif
    input  logic [NUM_IN*WIDTH-1:0] in,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic             w_adv;
    logic [SEL_W-1:0] w_effSel;

    // Every stage moves in lockstep; only a valid, unaccepted output item can freeze the pipe.
    assign w_adv    = !(out_valid && !out_ready);
    assign in_ready = w_adv;

`ifdef MUX_NX1_SCAN_EN
    logic             w_accept;
    logic [SEL_W-1:0] r_scanCnt;

    assign w_accept = in_valid && w_adv;
    assign w_effSel = scan_en ? r_scanCnt : sel;

    // Scan counter keeps its value across scan_en toggles so scanning resumes where it left off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scanCnt <= '0;
        end else if (w_accept && scan_en) begin
            r_scanCnt <= r_scanCnt + SEL_W'(1);
        end
    end
`else
    assign w_effSel = sel;
`endif

    for (genvar j = 0; j < SEL_W; j++) begin : g_stage
        localparam int N_OUT = NUM_IN >> (j + 1);

        logic [2*N_OUT*WIDTH-1:0] w_dIn;
        logic [SEL_W-1:0]         w_sIn;
        logic                     w_vIn;
        logic [N_OUT*WIDTH-1:0]   w_dMux;
        logic [N_OUT*WIDTH-1:0]   r_data;
        logic [SEL_W-1:0]         r_sel;
        logic                     r_valid;

        if (j == 0) begin : g_first
            assign w_dIn = in;
            assign w_sIn = w_effSel;
            assign w_vIn = in_valid;
        end else begin : g_next
            assign w_dIn = g_stage[j-1].r_data;
            assign w_sIn = g_stage[j-1].r_sel;
            assign w_vIn = g_stage[j-1].r_valid;
        end

        // Level j halves the surviving candidates using select bit j.
        always_comb begin
            w_dMux = '0;
            for (int k = 0; k < N_OUT; k++) begin
                w_dMux[k*WIDTH +: WIDTH] = w_sIn[j] ? w_dIn[(2*k+1)*WIDTH +: WIDTH]
                                                    : w_dIn[(2*k)*WIDTH +: WIDTH];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data  <= '0;
                r_sel   <= '0;
                r_valid <= 1'b0;
            end else if (w_adv) begin
                r_data  <= w_dMux;
                r_sel   <= w_sIn;
                r_valid <= w_vIn;
            end
        end
    end

    assign out       = g_stage[SEL_W-1].r_data;
    assign out_sel   = g_stage[SEL_W-1].r_sel;
    assign out_valid = g_stage[SEL_W-1].r_valid;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Randomized self-checking bench for mux_nx1_pipe (NUM_IN=8, WIDTH=8) against a latency/stall reference model.
// Scan-mode checks are included when MUX_NX1_SCAN_EN is defined.
module tb_mux_nx1_pipe;

    localparam int NUM_IN = 8;
    localparam int WIDTH  = 8;
    localparam int SEL_W  = 3;
    localparam int LAT    = SEL_W;

    logic                    clk;
    logic                    rst_n;
    logic                    scanEn;
    logic [NUM_IN*WIDTH-1:0] inBus;
    logic [SEL_W-1:0]        sel;
    logic                    inValid;
    logic                    inReady;
    logic [WIDTH-1:0]        outData;
    logic [SEL_W-1:0]        outSel;
    logic                    outValid;
    logic                    outReady;

    int checks = 0;
    int errors = 0;

    // Reference model: a LAT-deep delay line of accepted items that freezes while the output is stalled.
    logic             mValid [LAT];
    logic [WIDTH-1:0] mData  [LAT];
    logic [SEL_W-1:0] mSel   [LAT];
    logic [SEL_W-1:0] mCnt;

    mux_nx1_pipe #(.NUM_IN(NUM_IN), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MUX_NX1_SCAN_EN
        .scan_en   (scanEn),
`endif
        .in        (inBus),
        .sel       (sel),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .out       (outData),
        .out_sel   (outSel),
        .out_valid (outValid),
        .out_ready (outReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < LAT; i++) begin
            mValid[i] = 1'b0;
            mData[i]  = '0;
            mSel[i]   = '0;
        end
        mCnt = '0;
    endtask

    task automatic checkPipeOut();
        checkOutput("out_valid", 64'(outValid), 64'(mValid[LAT-1]));
        if (mValid[LAT-1]) begin
            checkOutput("out", 64'(outData), 64'(mData[LAT-1]));
            checkOutput("out_sel", 64'(outSel), 64'(mSel[LAT-1]));
        end
    endtask

    // Drives one cycle starting just after a falling edge and checks the result at the next falling edge.
    task automatic applyStimulus(input logic iv, input logic [NUM_IN*WIDTH-1:0] data,
                                 input logic [SEL_W-1:0] s, input logic ordy, output logic accepted);
        logic             expAdv;
        logic [SEL_W-1:0] eff;
        inValid  = iv;
        inBus    = data;
        sel      = s;
        outReady = ordy;
        #1;
        expAdv = !(mValid[LAT-1] && !ordy);
        checkOutput("in_ready", 64'(inReady), 64'(expAdv));
        accepted = expAdv && iv;
        if (expAdv) begin
            eff = scanEn ? mCnt : s;
            for (int i = LAT-1; i > 0; i--) begin
                mValid[i] = mValid[i-1];
                mData[i]  = mData[i-1];
                mSel[i]   = mSel[i-1];
            end
            mValid[0] = iv;
            mData[0]  = data[int'(eff)*WIDTH +: WIDTH];
            mSel[0]   = eff;
            if (iv && scanEn) mCnt = mCnt + 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        checkPipeOut();
    endtask

    function automatic logic [NUM_IN*WIDTH-1:0] randBus();
        return {$urandom, $urandom};
    endfunction

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, 64'(outValid), 64'd0);
        checkOutput({tag, "_out"}, 64'(outData), 64'd0);
        checkOutput({tag, "_sel"}, 64'(outSel), 64'd0);
        checkOutput({tag, "_ready"}, 64'(inReady), 64'd1);
    endtask

    initial begin
        logic                    acc;
        logic [NUM_IN*WIDTH-1:0] chan;
        int                      sent;

        rst_n    = 1'b0;
        scanEn   = 1'b0;
        inBus    = '0;
        sel      = '0;
        inValid  = 1'b0;
        outReady = 1'b0;
        clearModel();
        #1;
        checkResetState("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Channel k carries k*16+k; stream every select back to back.
        for (int k = 0; k < NUM_IN; k++) chan[k*WIDTH +: WIDTH] = WIDTH'(k * 17);
        for (int k = 0; k < NUM_IN; k++) applyStimulus(1'b1, chan, SEL_W'(k), 1'b1, acc);
        for (int k = 0; k < LAT; k++) applyStimulus(1'b0, chan, '0, 1'b1, acc);

        // Alternating bubbles must stay uncompressed.
        for (int k = 0; k < 12; k++) applyStimulus(1'(k % 2 == 0), randBus(), SEL_W'($urandom), 1'b1, acc);
        for (int k = 0; k < LAT; k++) applyStimulus(1'b0, randBus(), '0, 1'b1, acc);

        // Six items with a four-cycle downstream stall in the middle.
        sent = 0;
        for (int c = 0; c < 20 && sent < 6; c++) begin
            applyStimulus(1'b1, randBus(), SEL_W'($urandom), !(c >= 4 && c < 8), acc);
            if (acc) sent++;
        end
        checkOutput("stall_sent", 64'(sent), 64'd6);
        for (int k = 0; k < LAT + 1; k++) applyStimulus(1'b0, randBus(), '0, 1'b1, acc);

        // Bubble-only pipe with out_ready low must still accept.
        applyStimulus(1'b1, randBus(), SEL_W'($urandom), 1'b0, acc);
        checkOutput("bubble_accept", 64'(acc), 64'd1);
        for (int k = 0; k < LAT + 2; k++) applyStimulus(1'b0, randBus(), '0, 1'b1, acc);

        // Randomized traffic and backpressure.
        for (int c = 0; c < 400; c++)
            applyStimulus(1'($urandom_range(0, 3) != 0), randBus(), SEL_W'($urandom),
                          1'($urandom_range(0, 9) < 7), acc);
        for (int k = 0; k < LAT + 2; k++) applyStimulus(1'b0, randBus(), '0, 1'b1, acc);

        // Reset with three items in flight; none of them may emerge afterwards.
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, randBus(), SEL_W'($urandom), 1'b1, acc);
        inValid = 1'b0;
        rst_n   = 1'b0;
        #1;
        checkResetState("midreset");
        clearModel();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, randBus(), SEL_W'($urandom), 1'b1, acc);
        for (int k = 0; k < LAT + 2; k++) applyStimulus(1'b0, randBus(), '0, 1'b1, acc);

`ifdef MUX_NX1_SCAN_EN
        // Scan mode ignores sel; one plain accept in the middle must not disturb the counter.
        scanEn = 1'b1;
        for (int k = 0; k < 6; k++) applyStimulus(1'b1, randBus(), SEL_W'($urandom), 1'b1, acc);
        scanEn = 1'b0;
        applyStimulus(1'b1, randBus(), SEL_W'($urandom), 1'b1, acc);
        scanEn = 1'b1;
        for (int k = 0; k < 10; k++)
            applyStimulus(1'($urandom_range(0, 1)), randBus(), SEL_W'($urandom), 1'($urandom_range(0, 3) != 0), acc);
        scanEn = 1'b0;
        for (int k = 0; k < LAT + 2; k++) applyStimulus(1'b0, randBus(), '0, 1'b1, acc);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
